video_layer_compositor: RTL and testbench

Parametrised successor to the fixed video daisy chain. One block:
- generates the pixel scan (x, y) for NL layer sources;
- composites their returned pixels by per-layer enable and key colour, using fixed priority;
- delivers `{rgb, sof}` to the VGA sync core over a valid/ready stream with credit-based backpressure.

It sits between the video slot decoder/layer cores and `chu_vga_sync_core`, and replaces the hand-built frame counter, delay line and chain ordering.

---
 rtl/video_pkg.sv | 18 +
 rtl/video_pix_fifo.sv | 81 ++++++++
 rtl/video_pix_fifo_chk.sv | 18 +
 rtl/video_layer_compositor.sv | 219 +++++++++++++++++++++
 tb/tb_video_layer_compositor.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// Shared definitions for the video layer compositor: register map,
// default colour depth, scan coordinate width and run-control states.
package video_pkg;

    localparam int          CD_DEFAULT   = 12;
    localparam int          COORD_W      = 11;

    localparam logic [13:0] REG_CTRL     = 14'd0;
    localparam logic [13:0] REG_BG       = 14'd1;
    localparam logic [13:0] REG_KEY_BASE = 14'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } vlc_state_e;

endpackage

// File: rtl/video_pix_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on rd_data while
// the FIFO is non-empty; rd_data reads as zero when empty.
module video_pix_fifo #(
    parameter int DW    = 13,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_wr_s;
    logic          do_pop_s;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign do_pop_s = rd_en && !empty;
    // A pop frees a slot in the same cycle, so a write into a full FIFO is
    // accepted when it coincides with a pop.
    assign do_wr_s  = wr_en && (!full || do_pop_s);
    assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign count    = count_q;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr_s) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + CW'(do_wr_s) - CW'(do_pop_s);
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    video_pix_fifo_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (wr_en),
        .rd_en (do_pop_s),
        .full  (full)
    );

endmodule

// File: rtl/video_pix_fifo_chk.sv
// Overflow checker for the output pixel FIFO: a write into a full FIFO
// without a simultaneous pop would silently drop a pixel.
module video_pix_fifo_chk (
    input logic clk,
    input logic rst_n,
    input logic wr_en,
    input logic rd_en,
    input logic full
);

    // Flag any write that would overrun the FIFO.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(wr_en && full && !rd_en));
        end
    end

endmodule

// File: rtl/video_layer_compositor.sv
// Video layer compositor: scans (x, y) for NL layer cores, composites the
// returned pixels by enable/key with fixed priority (highest layer wins),
// and streams {rgb, sof} out through a credit-protected show-ahead FIFO.
module video_layer_compositor
    import video_pkg::*;
#(
    parameter int CD         = CD_DEFAULT,
    parameter int NL         = 4,
    parameter int HMAX       = 640,
    parameter int VMAX       = 480,
    parameter int LAT        = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk_sys,
    input  logic               reset_sys_n,
    input  logic               cs,
    input  logic               write,
    input  logic [13:0]        addr,
    input  logic [31:0]        wr_data,
    output logic [31:0]        rd_data,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    input  logic [NL*CD-1:0]   layer_rgb,
    output logic [CD:0]        m_data,
    output logic               m_valid,
    input  logic               m_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = CW + 1;
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(HMAX - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(VMAX - 1);

    // Control/status registers.
    logic              run_q, run_d;
    logic [NL-1:0]     layer_en_q, layer_en_d;
    logic [CD-1:0]     bg_q, bg_d;
    logic [CD-1:0]     key_q [NL];
    logic [CD-1:0]     key_d [NL];

    // Scan and run control.
    vlc_state_e         state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               active_s;
    logic               issue_s;
    logic               last_pix_s;

    // Delay line matching the layer-core latency.
    logic [LAT-1:0]     dl_vld_q, dl_vld_d;
    logic [LAT-1:0]     dl_sof_q, dl_sof_d;
    logic [SW-1:0]      inflight_s;
    logic [SW-1:0]      used_s;

    // Composite and output FIFO.
    logic [CD-1:0]      pix_rgb_s;
    logic [CW-1:0]      fifo_count_s;
    logic               fifo_empty_s;
    logic               fifo_full_s;

    // Register file write decode.
    always_comb begin
        run_d      = run_q;
        layer_en_d = layer_en_q;
        bg_d       = bg_q;
        key_d      = key_q;
        if (cs && write) begin
            if (addr == REG_CTRL) begin
                run_d      = wr_data[0];
                layer_en_d = wr_data[8 +: NL];
            end else if (addr == REG_BG) begin
                bg_d = wr_data[CD-1:0];
            end else begin
                for (int i = 0; i < NL; i++) begin
                    if (addr == (REG_KEY_BASE + 14'(i))) begin
                        key_d[i] = wr_data[CD-1:0];
                    end else begin
                        key_d[i] = key_q[i];
                    end
                end
            end
        end else begin
            run_d = run_q;
        end
    end

    // Register file state.
    always_ff @(posedge clk_sys or negedge reset_sys_n) begin
        if (!reset_sys_n) begin
            run_q      <= 1'b0;
            layer_en_q <= '0;
            bg_q       <= '0;
            for (int i = 0; i < NL; i++) begin
                key_q[i] <= '0;
            end
        end else begin
            run_q      <= run_d;
            layer_en_q <= layer_en_d;
            bg_q       <= bg_d;
            key_q      <= key_d;
        end
    end

    // Count delay-line stages still holding an issued pixel.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight_s = inflight_s + SW'(dl_vld_q[i]);
        end
    end

    // Credit check: only issue when every pixel already committed (queued
    // or in flight) plus this one still fits in the FIFO.
    assign active_s   = (state_q != ST_IDLE);
    assign used_s     = SW'(fifo_count_s) + inflight_s;
    assign issue_s    = active_s && !fifo_full_s && (used_s < SW'(FIFO_DEPTH));
    assign last_pix_s = (x_q == X_LAST) && (y_q == Y_LAST);

    // Scan advance, frame counting and run-control next state.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        frame_cnt_d = frame_cnt_q;
        if (issue_s) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d         = '0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else begin
                    y_d = y_q + 11'd1;
                end
            end else begin
                x_d = x_q + 11'd1;
            end
        end else begin
            x_d = x_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (run_q) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN, ST_DRAIN: begin
                // Clearing run lets the current frame finish before idling.
                if (run_q) begin
                    state_d = ST_RUN;
                end else if (issue_s && last_pix_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Shift issue and sof through the delay line.
    always_comb begin
        dl_vld_d = LAT'({dl_vld_q, issue_s});
        dl_sof_d = LAT'({dl_sof_q, issue_s && (x_q == '0) && (y_q == '0)});
    end

    // Scan, run-control and delay-line state.
    always_ff @(posedge clk_sys or negedge reset_sys_n) begin
        if (!reset_sys_n) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            frame_cnt_q <= '0;
            dl_vld_q    <= '0;
            dl_sof_q    <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            frame_cnt_q <= frame_cnt_d;
            dl_vld_q    <= dl_vld_d;
            dl_sof_q    <= dl_sof_d;
        end
    end

    // Priority search: later (higher) enabled, non-keyed layers override.
    always_comb begin
        pix_rgb_s = bg_q;
        for (int i = 0; i < NL; i++) begin
            pix_rgb_s = (layer_en_q[i] && (layer_rgb[i*CD +: CD] != key_q[i]))
                        ? layer_rgb[i*CD +: CD] : pix_rgb_s;
        end
    end

    video_pix_fifo #(
        .DW    (CD + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_sys),
        .rst_n   (reset_sys_n),
        .wr_en   (dl_vld_q[LAT-1]),
        .wr_data ({pix_rgb_s, dl_sof_q[LAT-1]}),
        .rd_en   (m_ready),
        .rd_data (m_data),
        .count   (fifo_count_s),
        .empty   (fifo_empty_s),
        .full    (fifo_full_s)
    );

    assign m_valid = !fifo_empty_s;
    assign x       = x_q;
    assign y       = y_q;
    assign rd_data = (addr == REG_CTRL) ? {frame_cnt_q, 14'd0, active_s, run_q} : 32'd0;

endmodule

// File: tb/tb_video_layer_compositor.sv
// Randomised self-checking bench for video_layer_compositor. A layer-core
// model answers x/y after LAT cycles; a raster-order reference predicts
// every output pixel from the register settings the bench programmed.
module tb_video_layer_compositor;

    localparam int CD    = 12;
    localparam int NL    = 4;
    localparam int HMAX  = 16;
    localparam int VMAX  = 6;
    localparam int LAT   = 4;
    localparam int FD    = 8;
    localparam int FRAME = HMAX * VMAX;

    logic              clk_sys = 1'b0;
    logic              reset_sys_n = 1'b1;
    logic              cs = 1'b0;
    logic              write = 1'b0;
    logic [13:0]       addr = 14'd0;
    logic [31:0]       wr_data = 32'd0;
    logic [31:0]       rd_data;
    logic [10:0]       x, y;
    logic [NL*CD-1:0]  layer_rgb;
    logic [CD:0]       m_data;
    logic              m_valid;
    logic              m_ready = 1'b0;

    int tests = 0;
    int fails = 0;

    // Reference state: what the bench has programmed and what it expects next.
    logic [CD-1:0] pat [NL][4];
    logic [NL-1:0] m_en = '0;
    logic [CD-1:0] m_bg = '0;
    logic [CD-1:0] m_key [NL];
    int            k = 0;
    int            pops = 0;
    int            sofs = 0;
    int            ready_mode = 0;
    logic          lit_en = 1'b0;
    logic [CD-1:0] lit_rgb = '0;
    int            cyc = 0;

    video_layer_compositor #(
        .CD(CD), .NL(NL), .HMAX(HMAX), .VMAX(VMAX), .LAT(LAT), .FIFO_DEPTH(FD)
    ) dut (
        .clk_sys(clk_sys), .reset_sys_n(reset_sys_n), .cs(cs), .write(write),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .x(x), .y(y),
        .layer_rgb(layer_rgb), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    function automatic int pidx(input int px, input int py, input int l);
        return (px * 7 + py * 3 + l) % 4;
    endfunction

    // Layer-core model: coordinates travel LAT cycles before the pixel appears.
    logic [10:0] xh [LAT];
    logic [10:0] yh [LAT];
    always @(posedge clk_sys) begin
        xh[0] <= x;
        yh[0] <= y;
        for (int i = 1; i < LAT; i++) begin
            xh[i] <= xh[i-1];
            yh[i] <= yh[i-1];
        end
    end

    always_comb begin
        layer_rgb = '0;
        for (int l = 0; l < NL; l++) begin
            layer_rgb[l*CD +: CD] = pat[l][pidx(int'(xh[LAT-1]), int'(yh[LAT-1]), l)];
        end
    end

    // Expected k-th output pixel of a run: raster position, then the top-most
    // enabled layer whose pixel is not its key colour, else background.
    function automatic logic [CD:0] expect_pix(input int n);
        int px, py;
        logic [CD-1:0] v;
        logic s;
        px = n % HMAX;
        py = (n / HMAX) % VMAX;
        s  = (px == 0) && (py == 0);
        for (int l = NL - 1; l >= 0; l--) begin
            v = pat[l][pidx(px, py, l)];
            if (m_en[l] && (v != m_key[l])) return {v, s};
        end
        return {m_bg, s};
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: checks the head every cycle it is valid, then decides ready.
    initial begin
        logic [CD:0] e;
        forever begin
            @(negedge clk_sys);
            if (reset_sys_n) begin
                if (m_valid) begin
                    e = expect_pix(k);
                    check("pixel", longint'(m_data), longint'(e));
                    if (lit_en) check("literal_rgb", longint'(m_data[CD:1]), longint'(lit_rgb));
                end
                case (ready_mode)
                    0:       m_ready = 1'b1;
                    1:       m_ready = ($urandom_range(0, 3) != 0);
                    default: m_ready = 1'b0;
                endcase
                if (m_valid && m_ready) begin
                    k++;
                    pops++;
                    if (m_data[0]) sofs++;
                end
            end else begin
                m_ready = 1'b0;
            end
        end
    end

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        @(negedge clk_sys);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(negedge clk_sys);
        cs = 1'b0; write = 1'b0; addr = 14'd0; wr_data = 32'd0;
    endtask

    task automatic set_ctrl(input logic run, input logic [NL-1:0] en);
        m_en = en;
        wr(14'd0, (32'(en) << 8) | 32'(run));
    endtask

    task automatic set_key(input int l, input logic [CD-1:0] kv);
        m_key[l] = kv;
        wr(14'(2 + l), 32'(kv));
    endtask

    task automatic set_bg(input logic [CD-1:0] b);
        m_bg = b;
        wr(14'd1, 32'(b));
    endtask

    task automatic wait_idle();
        int quiet = 0;
        int n = 0;
        while (quiet < LAT + 3 && n < 5000) begin
            @(negedge clk_sys);
            n++;
            if (rd_data[1] == 1'b0 && !m_valid) quiet++;
            else quiet = 0;
        end
        check("idle_reached", longint'(quiet >= LAT + 3), 64'd1);
    endtask

    task automatic fill_const(input int l, input logic [CD-1:0] v);
        for (int j = 0; j < 4; j++) pat[l][j] = v;
    endtask

    // Watchdog.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int c1, c2, n, lin0, lin1, fc0, issued;
        logic [NL-1:0] en_r;
        for (int l = 0; l < NL; l++) begin
            m_key[l] = '0;
            for (int j = 0; j < 4; j++) pat[l][j] = CD'($urandom);
        end

        // Reset state.
        #1 reset_sys_n = 1'b0;
        #20;
        check("reset_m_valid", longint'(m_valid), 64'd0);
        check("reset_m_data", longint'(m_data), 64'd0);
        check("reset_x", longint'(x), 64'd0);
        check("reset_y", longint'(y), 64'd0);
        check("reset_rd_data", longint'(rd_data), 64'd0);
        @(negedge clk_sys);
        reset_sys_n = 1'b1;

        // All layers disabled: background everywhere, one sof per frame, latency.
        ready_mode = 0;
        set_bg(12'h008);
        lit_rgb = 12'h008; lit_en = 1'b1;
        pops = 0; sofs = 0;
        set_ctrl(1'b1, 4'b0000);
        c1 = -1; c2 = -1; n = 0;
        while (c1 < 0 && n < 100) begin
            @(negedge clk_sys); n++;
            if (x == 11'd1) c1 = cyc;
        end
        while (c2 < 0 && n < 200) begin
            @(negedge clk_sys); n++;
            if (m_valid) c2 = cyc;
        end
        check("first_valid_latency", longint'(c2 - c1), longint'(LAT));
        repeat (30) @(negedge clk_sys);
        set_ctrl(1'b0, 4'b0000);
        wait_idle();
        check("frame_cnt_1", longint'(rd_data[31:16]), 64'd1);
        check("bg_frame_pixels", longint'(pops), longint'(FRAME));
        check("bg_frame_sofs", longint'(sofs), 64'd1);
        check("idle_x", longint'(x), 64'd0);
        check("idle_y", longint'(y), 64'd0);

        // Layers 3 and 1 enabled; layer 3 shows its key, so layer 1 wins.
        fill_const(0, 12'h111);
        fill_const(1, 12'hF00);
        fill_const(2, 12'h222);
        fill_const(3, 12'h000);
        set_key(1, 12'h123);
        set_key(3, 12'h000);
        lit_rgb = 12'hF00;
        set_ctrl(1'b1, 4'b1010);
        repeat (20) @(negedge clk_sys);
        set_ctrl(1'b0, 4'b1010);
        wait_idle();
        check("frame_cnt_2", longint'(rd_data[31:16]), 64'd2);

        // Layer 3 now shows a non-key colour and takes priority.
        fill_const(3, 12'h0F0);
        lit_rgb = 12'h0F0;
        set_ctrl(1'b1, 4'b1010);
        repeat (20) @(negedge clk_sys);
        set_ctrl(1'b0, 4'b1010);
        wait_idle();
        check("frame_cnt_3", longint'(rd_data[31:16]), 64'd3);

        // Randomised keys/enables/pixels with random backpressure and a long stall.
        lit_en = 1'b0;
        en_r = NL'($urandom_range(1, 15));
        for (int l = 0; l < NL; l++) begin
            set_key(l, CD'($urandom));
            pat[l][0] = m_key[l];
            for (int j = 1; j < 4; j++) pat[l][j] = CD'($urandom);
        end
        set_bg(CD'($urandom));
        fc0 = 3; pops = 0;
        ready_mode = 1;
        set_ctrl(1'b1, en_r);
        repeat (60) @(negedge clk_sys);
        ready_mode = 2;
        repeat (2) @(negedge clk_sys);
        lin0 = int'(y) * HMAX + int'(x);
        repeat (100) @(negedge clk_sys);
        lin1 = int'(y) * HMAX + int'(x);
        issued = (lin1 - lin0 + FRAME) % FRAME;
        check("stall_issue_bounded", longint'(issued <= FD), 64'd1);
        check("stall_valid_held", longint'(m_valid), 64'd1);
        ready_mode = 1;
        repeat (80) @(negedge clk_sys);
        set_ctrl(1'b0, en_r);
        repeat (5) @(negedge clk_sys);
        set_ctrl(1'b1, en_r);
        repeat (150) @(negedge clk_sys);
        set_ctrl(1'b0, en_r);
        wait_idle();
        check("random_whole_frames", longint'(pops % FRAME), 64'd0);
        check("random_frame_cnt", longint'(rd_data[31:16]) - longint'(fc0), longint'(pops / FRAME));
        check("random_idle_x", longint'(x), 64'd0);
        check("random_idle_y", longint'(y), 64'd0);

        // Reset mid-frame, then restart: first pixel carries sof.
        ready_mode = 0;
        set_ctrl(1'b1, en_r);
        repeat (30) @(negedge clk_sys);
        @(posedge clk_sys);
        #2 reset_sys_n = 1'b0;
        #1;
        check("midreset_m_valid", longint'(m_valid), 64'd0);
        check("midreset_x", longint'(x), 64'd0);
        check("midreset_y", longint'(y), 64'd0);
        check("midreset_rd_data", longint'(rd_data), 64'd0);
        k = 0; pops = 0; sofs = 0;
        m_en = '0; m_bg = '0;
        for (int l = 0; l < NL; l++) m_key[l] = '0;
        @(negedge clk_sys);
        reset_sys_n = 1'b1;
        set_bg(12'h5A5);
        lit_rgb = 12'h5A5; lit_en = 1'b1;
        set_ctrl(1'b1, 4'b0000);
        repeat (40) @(negedge clk_sys);
        set_ctrl(1'b0, 4'b0000);
        wait_idle();
        check("restart_frame_cnt", longint'(rd_data[31:16]), 64'd1);
        check("restart_pixels", longint'(pops), longint'(FRAME));
        check("restart_sofs", longint'(sofs), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
